// File: rtl/mem_port_arbiter_if.sv
// Handshake and bus signals between the core, the memory port and the arbiter.
// The arbiter uses the slave modport; the surrounding core/memory use master.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        flush_i;
  logic        d_load_i;
  logic        d_store_i;
  logic [2:0]  d_funct3_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_misalign_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i, d_load_i, d_store_i, d_funct3_i,
           d_addr_i, d_wdata_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o,
           d_misalign_o, stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i, d_load_i, d_store_i, d_funct3_i,
           d_addr_i, d_wdata_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o,
           d_misalign_o, stall_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
           mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and a one-entry load/store
// buffer; formats store lanes, extends load data, and drops flushed fetches.
module mem_port_arbiter #(
  parameter int unsigned FETCH_MAX_DEFER = 2,
  parameter int unsigned CNT_W           = 2
) (
  input logic               clk,
  input logic               rstl,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(FETCH_MAX_DEFER);

  state_t           state;
  logic             buf_valid;
  logic             buf_store;
  logic [2:0]       buf_funct3;
  logic [31:0]      buf_addr;
  logic [31:0]      buf_wdata;
  logic [CNT_W-1:0] defer_cnt;
  logic             fetch_owner;
  logic             kill;

  logic [1:0]  lane;
  logic        misalign;
  logic        fetch_first;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  assign lane        = buf_addr[1:0];
  assign fetch_first = bus.if_req_i && (defer_cnt == MAX_CNT);
  assign st_wdata    = buf_wdata << {lane, 3'b000};
  assign ld_shift    = bus.mem_rdata_i >> {lane, 3'b000};
  assign bus.stall_o = buf_valid;

  always_comb begin
    misalign = 1'b0;
    st_be    = 4'b1111;
    case (buf_funct3[1:0])
      2'b00:   st_be = 4'b0001 << lane;
      2'b01: begin
        st_be    = 4'b0011 << lane;
        misalign = lane[0];
      end
      default: misalign = (lane != 2'b00);
    endcase
  end

  always_comb begin
    ld_ext = ld_shift;
    case (buf_funct3)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstl) begin
      state            <= IDLE;
      buf_valid        <= 1'b0;
      buf_store        <= 1'b0;
      buf_funct3       <= '0;
      buf_addr         <= '0;
      buf_wdata        <= '0;
      defer_cnt        <= '0;
      fetch_owner      <= 1'b0;
      kill             <= 1'b0;
      bus.if_gnt_o     <= 1'b0;
      bus.if_rvalid_o  <= 1'b0;
      bus.if_rdata_o   <= '0;
      bus.d_rvalid_o   <= 1'b0;
      bus.d_rdata_o    <= '0;
      bus.d_misalign_o <= 1'b0;
      bus.mem_req_o    <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_be_o     <= '0;
      bus.mem_addr_o   <= '0;
      bus.mem_wdata_o  <= '0;
    end else begin
      bus.if_gnt_o     <= 1'b0;
      bus.if_rvalid_o  <= 1'b0;
      bus.if_rdata_o   <= '0;
      bus.d_rvalid_o   <= 1'b0;
      bus.d_rdata_o    <= '0;
      bus.d_misalign_o <= 1'b0;

      // A pulse into a full buffer is dropped; clears below only fire when full,
      // so capture and clear never collide on the same edge.
      if ((bus.d_load_i || bus.d_store_i) && !buf_valid) begin
        buf_valid  <= 1'b1;
        buf_store  <= bus.d_store_i;
        buf_funct3 <= bus.d_funct3_i;
        buf_addr   <= bus.d_addr_i;
        buf_wdata  <= bus.d_wdata_i;
      end

      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (buf_valid && misalign) begin
            state            <= ERR;
            buf_valid        <= 1'b0;
            bus.d_rvalid_o   <= 1'b1;
            bus.d_misalign_o <= 1'b1;
          end else if (buf_valid && !fetch_first) begin
            state           <= REQ;
            fetch_owner     <= 1'b0;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= buf_store;
            bus.mem_be_o    <= buf_store ? st_be : 4'b1111;
            bus.mem_addr_o  <= buf_addr & ~32'd3;
            bus.mem_wdata_o <= buf_store ? st_wdata : '0;
            if (bus.if_req_i && (defer_cnt != MAX_CNT))
              defer_cnt <= defer_cnt + 1'b1;
          end else if (bus.if_req_i) begin
            state           <= REQ;
            fetch_owner     <= 1'b1;
            defer_cnt       <= '0;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= 1'b0;
            bus.mem_be_o    <= 4'b1111;
            bus.mem_addr_o  <= bus.if_addr_i & ~32'd3;
            bus.mem_wdata_o <= '0;
          end
        end
        REQ: begin
          if (fetch_owner && bus.flush_i) kill <= 1'b1;
          if (bus.mem_ready_i) begin
            state           <= RSP;
            bus.if_gnt_o    <= fetch_owner;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_be_o    <= '0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
          end
        end
        RSP: begin
          if (bus.mem_rvalid_i) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (fetch_owner) begin
              if (!(kill || bus.flush_i)) begin
                bus.if_rvalid_o <= 1'b1;
                bus.if_rdata_o  <= bus.mem_rdata_i;
              end
            end else begin
              buf_valid      <= 1'b0;
              bus.d_rvalid_o <= 1'b1;
              bus.d_rdata_o  <= buf_store ? '0 : ld_ext;
            end
          end else if (fetch_owner && bus.flush_i) begin
            kill <= 1'b1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between instruction fetch and the load/store requests issued by the execute stage. The execute stage raises load_valid or store_valid as a one-cycle pulse, and this block captures each such request. It arbitrates against fetch, formats store byte lanes, and extends load data. It stalls the pipeline until the data access completes and drops fetch responses invalidated by a branch/jump flush.

Parameters:
FETCH_MAX_DEFER, 2, consecutive data grants allowed while fetch waits; after this many, fetch wins the next tie.
CNT_W, 2, width of the defer counter; must hold FETCH_MAX_DEFER.

Ports:
clk  input  1  clock, rising edge
rstl  input  1  reset, synchronous, active-low
if_req_i  input  1  fetch request, level, held until if_gnt_o
if_addr_i  input  32  fetch address, word aligned
if_gnt_o  output  1  one-cycle pulse: fetch accepted by memory
if_rvalid_o  output  1  one-cycle pulse: fetch data valid
if_rdata_o  output  32  fetch data
flush_i  input  1  branch/jump flush from execute stage
d_load_i  input  1  load request pulse (load_valid)
d_store_i  input  1  store request pulse (store_valid)
d_funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
d_addr_i  input  32  effective address
d_wdata_i  input  32  store data, right-aligned
d_rvalid_o  output  1  one-cycle pulse: data access complete (loads and stores)
d_rdata_o  output  32  extended load data; 0 for stores and errors
d_misalign_o  output  1  valid with d_rvalid_o: access was misaligned, not performed
stall_o  output  1  pipeline stall while a data access is pending
mem_req_o  output  1  memory request
mem_we_o  output  1  write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  32  word address, bits [1:0] = 0
mem_wdata_o  output  32  lane-shifted store data
mem_ready_i  input  1  memory accepts request this cycle
mem_rvalid_i  input  1  response or write acknowledge
mem_rdata_i  input  32  read data

Behaviour:
- Reset, sampled on the clk edge when rstl=0: every output is 0, FSM goes to IDLE, the data buffer is emptied, the defer counter is 0, and the fetch kill flag is cleared. Reset in the middle of a transaction abandons it; a later mem_rvalid_i is ignored.
- Data buffer holds one entry: op, funct3, addr, wdata. A d_load_i or d_store_i pulse loads it at the clock edge. A pulse that arrives while the buffer is full is a protocol violation; the buffer keeps its contents.
- stall_o = buffer valid. It is high from the cycle after capture, and it goes low in the same cycle d_rvalid_o pulses.
- FSM states:
  - IDLE: if the buffer is valid and the access is misaligned, go to ERR. Otherwise pick an owner and go to REQ.
  - REQ: mem_req_o=1 with registered fields. Wait for mem_ready_i. Fetch grant gives the if_gnt_o pulse in the next cycle.
  - RSP: wait for mem_rvalid_i, then go to IDLE.
  - ERR: one cycle; d_rvalid_o=1, d_misalign_o=1, then go to IDLE.
- Misaligned means: W with addr[1:0]≠0, or H/HU/SH with addr[0]=1.
- mem_rvalid_i seen outside RSP is ignored.
- Arbitration, in IDLE only:
  - Data beats fetch.
  - Exception: if if_req_i=1 and the defer counter equals FETCH_MAX_DEFER, fetch wins.
  - The counter increments on each data grant made while if_req_i=1, saturates, and clears on a fetch grant.
- Earliest latency:
  - Data pulse in cycle T: mem_req_o=1 in T+2 (capture into buffer, then IDLE decision).
  - With mem_ready_i in T+2 and mem_rvalid_i in T+3: d_rvalid_o=1 in T+4.
- Store formatting, with a = addr[1:0]:
  - mem_be_o = 0001<<a for B, 0011<<a for H, 1111 for W.
  - mem_wdata_o = d_wdata_i << 8*a.
  - mem_we_o=1.
- Load result, taken from mem_rdata_i >> 8*a, then extended:
  - B: sign-extend bits [7:0].
  - BU: zero-extend bits [7:0].
  - H: sign-extend bits [15:0].
  - HU: zero-extend bits [15:0].
  - W: unchanged.
  - Loads drive mem_be_o=1111, mem_we_o=0.
- Response outputs are registered: d_rvalid_o, d_rdata_o, if_rvalid_o and if_rdata_o are valid in the cycle after mem_rvalid_i. The buffer is cleared at the same edge.
- Flush:
  - flush_i=1 while fetch owns REQ or RSP, or together with the fetch response edge, sets the kill flag. Its if_rvalid_o is suppressed and if_rdata_o stays 0. The flag clears on return to IDLE.
  - flush_i in IDLE has no effect.
  - Data accesses are never affected by flush_i.
- Simultaneous data pulse and fetch completion: the pulse is captured, and the next IDLE arbitrates normally.

Test Plan:
- LW at addr 0x100, mem_rdata 0xDEADBEEF, memory ready immediately and rvalid one cycle later → mem_req in T+2 with be=1111, we=0; d_rvalid in T+4 with d_rdata=0xDEADBEEF; stall_o high T+1..T+3.
- LB at addr 0x103 with rdata 0x80000000 → d_rdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008000.
- SB at 0x201 with wdata 0x000000AB → mem_addr=0x200, be=0010, mem_wdata=0x0000AB00, we=1; d_rvalid pulses with rdata 0.
- LW at 0x102 → no mem_req; d_rvalid=1 and d_misalign=1 in T+2; stall_o low in T+2.
- if_req held while data pulses arrive back-to-back (each issued after the previous d_rvalid), FETCH_MAX_DEFER=2 → exactly 2 data grants, then if_gnt before the third data access.
- Fetch at 0x40 in RSP, flush_i pulsed, mem_rvalid follows → no if_rvalid. The next fetch at 0x80 returns normally. Separately, reset asserted during RSP → all outputs 0 next cycle and the late mem_rvalid is ignored.
